// File: rtl/r51_pkg.sv
// r51_pkg: shared types and constants for the R51 program loader
package r51_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WRITE, BOOT, RUN} state_t;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic [7:0] NOP = 8'h00;
    localparam int BOOT_CYCLES = 2;
endpackage

// File: rtl/r51_loader_if.sv
// r51_loader_if: image byte stream plus RAM1 write port of the loader
interface r51_loader_if #(
    parameter int ADDR_WIDTH = r51_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = r51_pkg::DEF_DATA_WIDTH
);
    logic in_valid;
    logic in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic in_last;
    logic prog_we;
    logic [ADDR_WIDTH-1:0] prog_addr;
    logic [DATA_WIDTH-1:0] prog_data;
    modport master (
        input  in_valid, in_data, in_last,
        output in_ready, prog_we, prog_addr, prog_data
    );
    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/r51_loader.sv
// r51_loader: clears and loads R51 program memory from a byte stream, then boots and runs the R51
module r51_loader
    import r51_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                timer555,
    input  logic                reset_count,
    input  logic                load_req,
    input  logic                start,
    input  logic                stop,
    r51_loader_if.master        bus,
    output logic                cpu_reset,
    output logic                cpu_run,
    output logic                busy,
    output logic [ADDR_WIDTH:0] word_count,
    output logic                err
);
    localparam logic [1:0] BOOT_LAST = 2'(BOOT_CYCLES - 1);
    state_t state, state_d;
    logic [ADDR_WIDTH-1:0] ptr, ptr_d;
    logic [ADDR_WIDTH:0] wc_d;
    logic err_d, last_q, last_d;
    logic [1:0] boot_cnt, boot_d;
    always_comb begin
        state_d = state;
        ptr_d = ptr;
        wc_d = word_count;
        err_d = err;
        last_d = last_q;
        boot_d = boot_cnt;
        case (state)
            IDLE: begin
                if (load_req) begin
                    state_d = CLEAR;
                    ptr_d = '0;
                    wc_d = '0;
                    err_d = 1'b0;
                end else if (start && word_count != '0) begin
                    state_d = BOOT;
                    boot_d = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr + 1'b1;
                state_d = ptr == '1 ? LOAD : CLEAR;
            end
            LOAD: begin
                if (bus.in_valid) begin
                    state_d = WRITE;
                    last_d = bus.in_last;
                end
            end
            // a full memory without in_last ends the load with an overflow
            WRITE: begin
                ptr_d = ptr + 1'b1;
                wc_d = word_count + 1'b1;
                err_d = err | (!last_q && ptr == '1);
                state_d = (last_q || ptr == '1) ? IDLE : LOAD;
            end
            BOOT: begin
                boot_d = boot_cnt + 1'b1;
                state_d = boot_cnt == BOOT_LAST ? RUN : BOOT;
            end
            RUN: state_d = stop ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end
    // outputs are registered from the next-state values so they align with the state
    always_ff @(posedge timer555) begin
        if (reset_count) begin
            state <= IDLE;
            ptr <= '0;
            word_count <= '0;
            err <= 1'b0;
            last_q <= 1'b0;
            boot_cnt <= '0;
            bus.in_ready <= 1'b0;
            bus.prog_we <= 1'b0;
            bus.prog_addr <= '0;
            bus.prog_data <= '0;
            cpu_reset <= 1'b1;
            cpu_run <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_d;
            ptr <= ptr_d;
            word_count <= wc_d;
            err <= err_d;
            last_q <= last_d;
            boot_cnt <= boot_d;
            bus.in_ready <= state_d == LOAD;
            bus.prog_we <= state_d == CLEAR || state_d == WRITE;
            bus.prog_addr <= ptr_d;
            bus.prog_data <= state_d == WRITE ? bus.in_data : DATA_WIDTH'(NOP);
            cpu_reset <= state_d != RUN;
            cpu_run <= state_d == RUN;
            busy <= !(state_d == IDLE || state_d == RUN);
        end
    end
endmodule

// File: doc/r51_loader.md
# r51_loader

Program loader and run controller sitting directly upstream of the R51 datapath. Accepts a program image as a byte stream over a valid/ready handshake, clears and writes the R51 program memory (RAM1) one word per write strobe, then releases the R51 from reset and lets it run. Replaces manual data-switch/button entry of RAM1 with a deterministic sequenced load.

## Interface
- ADDR_WIDTH, 3, program-memory address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, program word width
- timer555  in  1  system clock; all state updates on rising edge
- reset_count  in  1  synchronous, active-high reset
- load_req  in  1  one-cycle request to clear memory and load a new image
- start  in  1  one-cycle request to reset and run the R51
- stop  in  1  one-cycle request to halt the R51
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader accepts a byte this cycle
- in_data  in  DATA_WIDTH  stream byte (program word)
- in_last  in  1  marks final byte of image, qualified by in_valid
- prog_we  out  1  RAM1 write strobe, one cycle per word
- prog_addr  out  ADDR_WIDTH  RAM1 write address
- prog_data  out  DATA_WIDTH  RAM1 write data
- cpu_reset  out  1  drives R51 counter reset
- cpu_run  out  1  R51 clock enable
- busy  out  1  high in any state other than IDLE and RUN
- word_count  out  ADDR_WIDTH+1  words written by the last load
- err  out  1  image overflowed memory (sticky until next load_req or reset)

## Operation
- States: IDLE, CLEAR, LOAD, WRITE, BOOT, RUN.
- Reset values: state IDLE; in_ready 0, prog_we 0, prog_addr 0, prog_data 0, cpu_reset 1, cpu_run 0, busy 0, word_count 0, err 0.
- IDLE: cpu_reset 1, cpu_run 0. load_req -> CLEAR (clears err, word_count, address pointer). start with word_count != 0 -> BOOT; start with word_count == 0 ignored. load_req and start together: load_req wins.
- CLEAR: prog_we 1, prog_data 0 (NOP), prog_addr steps 0 .. 2**ADDR_WIDTH-1, one address per cycle; after the last address -> LOAD with pointer 0.
- LOAD: in_ready 1. On in_valid & in_ready: capture in_data and pointer -> WRITE.
- WRITE: prog_we 1 for exactly one cycle with captured data/address; word_count increments; pointer increments (wraps only via termination below). Then:
  - in_last on the captured byte -> IDLE.
  - pointer was 2**ADDR_WIDTH-1 and in_last 0 -> err 1, -> IDLE; further stream bytes are not accepted (in_ready 0).
  - otherwise -> LOAD.
- BOOT: cpu_reset 1, cpu_run 0 for exactly 2 cycles, then -> RUN.
- RUN: cpu_reset 0, cpu_run 1. stop -> IDLE. load_req in RUN ignored; stop takes precedence over start.
- start, stop, load_req outside the states named above are ignored.
- reset_count in any state (mid-clear, mid-load, running) returns all outputs to reset values in the next cycle; partially written memory is not restored.
- word_count arithmetic: unsigned ADDR_WIDTH+1 bits, max 2**ADDR_WIDTH, never wraps.

## Timing
- All outputs registered; change one cycle after the causing edge.
- Handshake: byte transfers on the rising edge where in_valid & in_ready; in_ready drops in the following cycle (WRITE), so peak throughput is one byte per 2 cycles.
- Accept-to-write latency: prog_we high exactly 1 cycle after the accepting edge.
- Clear: 2**ADDR_WIDTH cycles (8 at default) of prog_we, starting the cycle after load_req.
- Start-to-run: cpu_run high 3 cycles after the start edge (1 to enter BOOT, 2 in BOOT).
- Stop: cpu_run low and cpu_reset high 1 cycle after the stop edge.

## Structure
- Shared package r51_pkg: state enum type, default ADDR_WIDTH/DATA_WIDTH constants, NOP word constant (8'h00), BOOT_CYCLES constant (2).
- Single module, no sub-module; the FSM, address pointer and word counter are small enough to live together.

## Test plan
- Reset then load_req -> prog_we high 8 cycles, prog_addr 0..7, prog_data 0; then in_ready 1.
- Stream 3 bytes 8'h41, 8'h52, 8'h83 (last on third) -> writes addr0=41, addr1=52, addr2=83, one cycle after each accept; word_count 3, err 0, back to IDLE.
- Stream 9 bytes, no in_last -> 8 writes to addr 0..7, err 1, word_count 8, 9th byte never accepted.
- start after valid load -> cpu_reset high 2 more cycles, cpu_run 1 on cycle 3; stop -> cpu_run 0, cpu_reset 1 next cycle; start with word_count 0 -> no change.
- reset_count asserted mid-LOAD after 2 bytes -> next cycle all outputs at reset values, word_count 0, in_ready 0.
- load_req and start same cycle in IDLE -> CLEAR entered, cpu_run stays 0.
